mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
// - Multi-cycle signed 32-bit multiply/divide unit in the execute stage; feeds the EX/MEM latch (mult_latch_3) data/reg/ins inputs.
// - Holds the pipeline via stall while iterating.
// - Carries the instruction word and destination-register tag alongside the result, so they reach the latch aligned with the result.
// PARAMETERS
// - WIDTH    32  operand/result width
// - CNT_W    6   iteration counter width; must hold WIDTH
// PORTS
// - clock          in   1      rising-edge clock
// - reset          in   1      reset, asynchronous, active-low (0 = reset)
// - data_operandA  in   WIDTH  multiplicand / dividend (signed)
// - data_operandB  in   WIDTH  multiplier / divisor (signed)
// - ctrl_MULT      in   1      1-cycle start pulse, multiply
// - ctrl_DIV       in   1      1-cycle start pulse, divide
// - reg_input      in   32     destination-register tag, captured at start
// - ins_input      in   32     instruction word, captured at start
// - data_result    out  WIDTH  product (low WIDTH bits) or quotient
// - data_exception out  1      overflow or divide-by-zero; valid with data_resultRDY
// - data_resultRDY out  1      1-cycle pulse: result/tag/ins valid
// - stall          out  1      1 while an operation is in flight
// - reg_output     out  32     captured reg_input
// - ins_output     out  32     captured ins_input
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; all outputs 0; counter 0; internal regs cleared.
// - States:
//   - IDLE -> MULT on ctrl_MULT; IDLE -> DIV on ctrl_DIV.
//   - MULT/DIV -> DONE when the counter reaches WIDTH.
//   - DONE -> IDLE after one cycle.
// - Start (IDLE, start pulse): latch |A|, |B|, result sign (A[31]^B[31]), reg_input and ins_input; counter = 0.
//   - stall rises the cycle after the pulse.
// - Start priority and gating:
//   - ctrl_MULT and ctrl_DIV both high: multiply wins; DIV is ignored.
//   - Start pulses outside IDLE are ignored and do not disturb the operation in flight.
// - MULT: radix-2 shift-add on magnitudes, one multiplier bit per cycle, 2*WIDTH accumulator; WIDTH iterations.
// - DIV: restoring divide on magnitudes, one quotient bit per cycle; WIDTH iterations; remainder discarded.
// - DONE: apply sign (two's complement negate if sign=1).
//   - Result, reg_output and ins_output update; data_resultRDY=1 for exactly this cycle; stall falls in this cycle.
//   - Start-to-RDY latency = WIDTH+2 cycles (pulse at cycle 0, RDY at cycle 34 for WIDTH=32).
// - Multiply overflow: data_exception=1 when the signed 2*WIDTH product does not fit in WIDTH signed bits; data_result = low WIDTH bits.
// - Divide by zero: detected at start; skip iteration, go directly to DONE.
//   - Outputs: data_result=0, data_exception=1; RDY at cycle 2 after the pulse.
// - Divide special case: -2^31 / -1 gives data_result=0x80000000 and data_exception=1.
// - Output holding:
//   - data_result, data_exception, reg_output and ins_output hold their values until the next DONE.
//   - data_resultRDY and stall are 0 in IDLE.
// - Reset mid-operation aborts immediately.
//   - All outputs 0; no RDY pulse is produced for the aborted operation.
// CONFIGURATION
// - MULTDIV_EARLY_TERM_EN defined: MULT goes to DONE as soon as the remaining shifted multiplier magnitude is zero.
//   - Latency = 2 + index of highest set bit of |B| + 1; B=0 gives RDY at cycle 2.
//   - DIV is unchanged.
// - Not defined: fixed WIDTH+2 latency for MULT.
// - Results and exceptions are identical in both builds.
// TESTING
// - MULT A=6, B=-7 -> RDY at cycle 34: result=0xFFFFFFD6 (-42), exception=0, stall high cycles 1-33.
// - MULT A=0x00010000, B=0x00010000 -> exception=1, result=0x00000000.
// - DIV A=-100, B=7 -> result=-14 (0xFFFFFFF2), exception=0.
// - DIV A=5, B=0 -> RDY at cycle 2: result=0, exception=1.
// - Start with reg_input=0x1F, ins_input=0xDEADBEEF; apply ctrl_DIV while busy -> ignored; outputs 0x1F/0xDEADBEEF at RDY.
// - Reset=0 at cycle 10 of MULT -> outputs 0 at once, no RDY; a new MULT 3*3 after release -> 9.

Source files
------------

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle signed multiply / divide unit for the execute stage. It works
//   on operand magnitudes (shift-add multiply, restoring divide, one bit per
//   cycle) and applies the result sign on the final cycle. The destination
//   register tag and instruction word are captured at start so that they leave
//   the unit on the same cycle as the result.
//
//   Build option: MULTDIV_EARLY_TERM_EN
//     defined   - MULT finishes as soon as the remaining multiplier magnitude
//                 is zero (latency = 2 + index of highest set bit of |B| + 1).
//     undefined - MULT always takes WIDTH iterations (latency WIDTH+2).
//     DIV timing and all results/exceptions are identical in both builds.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-low reset
//   data_operandA   multiplicand / dividend (signed)
//   data_operandB   multiplier / divisor (signed)
//   ctrl_MULT       1-cycle start pulse, multiply (wins over ctrl_DIV)
//   ctrl_DIV        1-cycle start pulse, divide
//   reg_input       destination-register tag, captured at start
//   ins_input       instruction word, captured at start
//   data_result     low WIDTH bits of product, or quotient
//   data_exception  multiply overflow / divide-by-zero / quotient overflow
//   data_resultRDY  1-cycle pulse: result, tag and instruction valid
//   stall           high while an operation is in flight
//   reg_output      captured reg_input
//   ins_output      captured ins_input
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [31:0]      reg_input,
  input  logic [31:0]      ins_input,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             stall,
  output logic [31:0]      reg_output,
  output logic [31:0]      ins_output
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_0   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_1   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH);

  // Two's complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + ONE_W;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // True when a 2*WIDTH signed value is representable in WIDTH signed bits.
  function automatic logic fits_signed(input logic [2*WIDTH-1:0] p);
    logic [WIDTH:0] top;
    top = p[2*WIDTH-1:WIDTH-1];
    return (&top) | (~|top);
  endfunction

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_a_mag;   // DIV: dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]     r_b_mag;   // MULT: multiplier shifting right; DIV: divisor
  logic [2*WIDTH-1:0]   r_mcand;   // MULT: multiplicand shifted left each step
  logic [2*WIDTH-1:0]   r_acc;     // MULT: product; DIV: low WIDTH bits hold remainder
  logic                 r_sign;
  logic                 r_dz;
  logic [31:0]          r_reg;
  logic [31:0]          r_ins;

  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_prod_signed;
  logic                 w_mult_ovf;
  logic                 w_mult_done;
  logic [WIDTH:0]       w_rem_shift;
  logic                 w_rem_ge;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;
  logic [WIDTH-1:0]     w_quo_signed;
  logic                 w_div_ovf;

  // Datapath step values and final sign/overflow evaluation.
  always_comb begin
    w_acc_next    = r_acc;
    w_rem_next    = w_rem_shift[WIDTH-1:0];
    w_prod_signed = r_acc;
    w_quo_signed  = r_a_mag;

    if (r_b_mag[0]) begin
      w_acc_next = r_acc + r_mcand;
    end else begin
      w_acc_next = r_acc;
    end

    if (r_sign) begin
      w_prod_signed = ~r_acc + ONE_2W;
      w_quo_signed  = ~r_a_mag + ONE_W;
    end else begin
      w_prod_signed = r_acc;
      w_quo_signed  = r_a_mag;
    end
    w_mult_ovf = ~fits_signed(w_prod_signed);

    // Restoring step: bring in next dividend bit, subtract divisor if it fits.
    w_rem_shift = {r_acc[WIDTH-1:0], r_a_mag[WIDTH-1]};
    w_rem_ge    = (w_rem_shift >= {1'b0, r_b_mag});
    if (w_rem_ge) begin
      w_rem_next = w_rem_shift[WIDTH-1:0] - r_b_mag;
    end else begin
      w_rem_next = w_rem_shift[WIDTH-1:0];
    end
    w_quo_next = {r_a_mag[WIDTH-2:0], w_rem_ge};

    // Positive quotient of magnitude 2^(WIDTH-1) only arises from MIN / -1.
    w_div_ovf = ~r_sign & r_a_mag[WIDTH-1];

`ifdef MULTDIV_EARLY_TERM_EN
    w_mult_done = (r_b_mag == ZERO_W);
`else
    w_mult_done = (r_cnt == CNT_END);
`endif
  end

  // Control FSM with iteration datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= CNT_0;
      r_a_mag        <= ZERO_W;
      r_b_mag        <= ZERO_W;
      r_mcand        <= ZERO_2W;
      r_acc          <= ZERO_2W;
      r_sign         <= 1'b0;
      r_dz           <= 1'b0;
      r_reg          <= 32'd0;
      r_ins          <= 32'd0;
      data_result    <= ZERO_W;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      stall          <= 1'b0;
      reg_output     <= 32'd0;
      ins_output     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_MULT || ctrl_DIV) begin
            r_cnt   <= CNT_0;
            r_sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_reg   <= reg_input;
            r_ins   <= ins_input;
            r_a_mag <= abs_val(data_operandA);
            r_b_mag <= abs_val(data_operandB);
            r_mcand <= {ZERO_W, abs_val(data_operandA)};
            r_acc   <= ZERO_2W;
            stall   <= 1'b1;
            if (ctrl_MULT) begin
              r_state <= S_MULT;
              r_dz    <= 1'b0;
            end else begin
              r_state <= S_DIV;
              r_dz    <= (data_operandB == ZERO_W);
            end
          end else begin
            r_state <= S_IDLE;
            stall   <= 1'b0;
          end
        end

        S_MULT: begin
          if (w_mult_done) begin
            r_state        <= S_DONE;
            data_result    <= w_prod_signed[WIDTH-1:0];
            data_exception <= w_mult_ovf;
            data_resultRDY <= 1'b1;
            stall          <= 1'b0;
            reg_output     <= r_reg;
            ins_output     <= r_ins;
          end else begin
            r_acc   <= w_acc_next;
            r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_b_mag <= {1'b0, r_b_mag[WIDTH-1:1]};
            r_cnt   <= r_cnt + CNT_1;
          end
        end

        S_DIV: begin
          if (r_dz) begin
            r_state        <= S_DONE;
            data_result    <= ZERO_W;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            stall          <= 1'b0;
            reg_output     <= r_reg;
            ins_output     <= r_ins;
          end else if (r_cnt == CNT_END) begin
            r_state        <= S_DONE;
            data_result    <= w_quo_signed;
            data_exception <= w_div_ovf;
            data_resultRDY <= 1'b1;
            stall          <= 1'b0;
            reg_output     <= r_reg;
            ins_output     <= r_ins;
          end else begin
            r_acc   <= {ZERO_W, w_rem_next};
            r_a_mag <= w_quo_next;
            r_cnt   <= r_cnt + CNT_1;
          end
        end

        S_DONE: begin
          r_state        <= S_IDLE;
          data_resultRDY <= 1'b0;
          stall          <= 1'b0;
        end

        default: begin
          r_state        <= S_IDLE;
          data_resultRDY <= 1'b0;
          stall          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Scoreboard bench: the driver computes expected result, exception, tag,
//   instruction word and latency from plain signed arithmetic and pushes them
//   into a queue; an independent monitor pops and compares on every RDY pulse.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] reg_input;
  logic [31:0] ins_input;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        stall;
  logic [31:0] reg_output;
  logic [31:0] ins_output;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .reg_input      (reg_input),
    .ins_input      (ins_input),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .stall          (stall),
    .reg_output     (reg_output),
    .ins_output     (ins_output)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rg;
    logic [31:0] ins;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model straight from signed arithmetic.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc, output int lat);
    longint sa, sb, p, q, mag;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      p   = sa * sb;
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`ifdef MULTDIV_EARLY_TERM_EN
      mag = (sb < 0) ? -sb : sb;
      if (mag == 0) begin
        lat = 2;
      end else begin
        lat = 2;
        for (int k = 0; k < 33; k++) begin
          if (mag[k]) lat = 3 + k;
        end
      end
`else
      mag = 0;
      lat = 34;
`endif
    end else begin
      if (sb == 0) begin
        res = 32'd0;
        exc = 1'b1;
        lat = 2;
      end else begin
        q   = sa / sb;
        res = q[31:0];
        exc = (q > 64'sd2147483647);
        lat = 34;
      end
    end
  endtask

  // Monitor: compare every RDY pulse with the scoreboard head; stall must stay
  // high while an operation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (data_resultRDY) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rdy", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", data_result, e.res);
          chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
          chk("reg_output", reg_output, e.rg);
          chk("ins_output", ins_output, e.ins);
          chk("latency", 32'(cyc - e.start), 32'(e.lat));
          chk("stall_at_rdy", {31'd0, stall}, 32'd0);
        end
      end else if (reset && sb_q.size() > 0 && (cyc - sb_q[0].start) >= 1) begin
        chk("stall_busy", {31'd0, stall}, 32'd1);
      end
    end
  end

  // Issue one operation; optionally inject a second start pulse while busy.
  task automatic do_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rg, input logic [31:0] ins,
                       input bit inject, input bit both);
    exp_t e;
    bit   done;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    reg_input     = rg;
    ins_input     = ins;
    ctrl_MULT     = is_mult | both;
    ctrl_DIV      = ~is_mult | both;
    model(is_mult | both, a, b, e.res, e.exc, e.lat);
    e.rg    = rg;
    e.ins   = ins;
    e.start = cyc;
    sb_q.push_back(e);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    if (inject) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
      reg_input     = $urandom;
      ins_input     = $urandom;
      ctrl_DIV      = 1'b1;
      ctrl_MULT     = $urandom_range(0, 1) == 1;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (sb_q.size() == 0) done = 1'b1;
      else @(negedge clock);
    end
    if (!done) begin
      chk("timeout_no_rdy", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 200));
      2: v = -32'($urandom_range(0, 200));
      3: v = 32'h8000_0000;
      4: v = 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  initial begin
    reset         = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    reg_input     = 32'd0;
    ins_input     = 32'd0;

    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_reg", reg_output, 32'd0);
    chk("reset_ins", ins_output, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Directed cases
    do_op(1'b1, 32'd6, -32'd7, 32'd3, 32'h1111_0001, 1'b0, 1'b0);
    do_op(1'b1, 32'h0001_0000, 32'h0001_0000, 32'd4, 32'h1111_0002, 1'b0, 1'b0);
    do_op(1'b0, -32'd100, 32'd7, 32'd5, 32'h1111_0003, 1'b0, 1'b0);
    do_op(1'b0, 32'd5, 32'd0, 32'd6, 32'h1111_0004, 1'b0, 1'b0);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'h1111_0005, 1'b0, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd8, 32'h1111_0006, 1'b0, 1'b0);
    do_op(1'b1, 32'd12, 32'd0, 32'd9, 32'h1111_0007, 1'b0, 1'b0);
    do_op(1'b1, -32'd9, 32'd11, 32'd10, 32'h1111_0008, 1'b0, 1'b1);
    do_op(1'b0, 32'd1000, -32'd3, 32'h1F, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Reset in the middle of a multiply: aborted, no RDY afterwards.
    @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = -32'd5;
    reg_input     = 32'h22;
    ins_input     = 32'h3333_4444;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_result", data_result, 32'd0);
    chk("abort_reg", reg_output, 32'd0);
    chk("abort_ins", ins_output, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    do_op(1'b1, 32'd3, 32'd3, 32'h23, 32'h5555_6666, 1'b0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      do_op($urandom_range(0, 1) == 1, rand_operand(), rand_operand(),
            $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
